button_debounce: RTL and testbench

- Input conditioner for front-panel push buttons: synchronises a raw asynchronous switch, filters contact bounce on the slow `clk_en` tick, and drives the clean `button` level consumed by the auto-repeat pulse generator.
- Also emits single-clock press/release edge pulses and an optional long-press pulse for the time-setting logic.
- One instance per physical button, in the same `clk`/`clk_en` domain as the pulse generator.

---
 rtl/button_debounce.sv | 129 ++++++++++++
 tb/tb_button_debounce.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: input synchroniser, clk_en-paced debounce filter, press/release edge pulses.
// Optional long-press detection is built when BUTTON_LONG_PRESS_EN is defined; otherwise long_press is tied to 0.
module button_debounce #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int LONG_COUNT     = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_en,
    input  logic button_in,
    output logic button,
    output logic pressed,
    output logic released,
    output logic long_press
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_COUNT < 1) begin : g_chk_deb
        $error("DEBOUNCE_COUNT must be >= 1");
    end
    if (LONG_COUNT < 1) begin : g_chk_long
        $error("LONG_COUNT must be >= 1");
    end

    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   button_q, button_d;
    logic                   pressed_q, pressed_d;
    logic                   released_q, released_d;
    logic                   flip;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser chain shifts every clock, independent of clk_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
        end
    end

    // Debounce filter: count consecutive ticks where sync disagrees with button.
    always_comb begin
        cnt_d    = cnt_q;
        button_d = button_q;
        flip     = 1'b0;
        if (clk_en) begin
            if (sync == button_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                button_d = sync;
                cnt_d    = '0;
                flip     = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Edge pulses are registered alongside button so they appear in the same cycle.
    always_comb begin
        pressed_d  = flip & sync;
        released_d = flip & ~sync;
    end

    // Debounce state and edge pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            button_q   <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            button_q   <= button_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign button   = button_q;
    assign pressed  = pressed_q;
    assign released = released_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_COUNT + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_COUNT);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Hold counter saturates so long_press fires only once per press;
    // a release qualifying on the same tick suppresses the pulse.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!button_q) begin
            hold_d = '0;
        end else if (clk_en && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_d == HOLD_MAX) && !released_d;
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce with default parameters.
// Long-press expectations follow BUTTON_LONG_PRESS_EN.
module tb_button_debounce;

`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    logic clk_en;
    logic button_in;
    logic button;
    logic pressed;
    logic released;
    logic long_press;

    int n_chk;
    int n_err;

    button_debounce dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .button_in  (button_in),
        .button     (button),
        .pressed    (pressed),
        .released   (released),
        .long_press (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input bit b, input bit p,
                               input bit r, input bit l);
        chk({tag, ".button"}, 32'(button), 32'(b));
        chk({tag, ".pressed"}, 32'(pressed), 32'(p));
        chk({tag, ".released"}, 32'(released), 32'(r));
        chk({tag, ".long"}, 32'(long_press), 32'(l));
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        clk_en    = 1'b0;
        button_in = 1'b0;
        tick();
        tick();
        expect_outs("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        clk_en  = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            expect_outs($sformatf("idle%0d", e), 0, 0, 0, 0);
        end

        // clean press, held long enough for long_press
        button_in = 1'b1;
        for (int e = 1; e <= 76; e++) begin
            tick();
            expect_outs($sformatf("press%0d", e), e >= 6, e == 6, 0,
                        LP_EN && (e == 70));
        end
        button_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect_outs($sformatf("rel%0d", e), e < 6, 0, e == 6, 0);
        end

        // bounce: single low sample restarts the count
        for (int e = 1; e <= 12; e++) begin
            button_in = (e == 4) ? 1'b0 : 1'b1;
            tick();
            expect_outs($sformatf("bounce%0d", e), e >= 10, e == 10, 0, 0);
        end
        button_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect_outs($sformatf("brel%0d", e), e < 6, 0, e == 6, 0);
        end

        // sparse clk_en: every 4th clock
        button_in = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            clk_en = ((e % 4) == 3);
            tick();
            expect_outs($sformatf("sparse%0d", e), e >= 15, e == 15, 0, 0);
        end
        clk_en    = 1'b1;
        button_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect_outs($sformatf("srel%0d", e), e < 6, 0, e == 6, 0);
        end

        // release before LONG_COUNT: no long_press
        for (int e = 1; e <= 58; e++) begin
            button_in = (e <= 45);
            tick();
            expect_outs($sformatf("short%0d", e), (e >= 6) && (e < 51),
                        e == 6, e == 51, 0);
        end

        // release qualifies on the tick the hold counter would hit LONG_COUNT
        for (int e = 1; e <= 76; e++) begin
            button_in = (e <= 64);
            tick();
            expect_outs($sformatf("tie%0d", e), (e >= 6) && (e < 70),
                        e == 6, e == 70, 0);
        end

        // reset in the middle of a held press
        button_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            expect_outs($sformatf("hold%0d", e), e >= 6, e == 6, 0, 0);
        end
        reset_n = 1'b0;
        #1;
        expect_outs("rst_async", 0, 0, 0, 0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            expect_outs($sformatf("rst%0d", e), 0, 0, 0, 0);
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect_outs($sformatf("requal%0d", e), e >= 6, e == 6, 0, 0);
        end
        button_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect_outs($sformatf("frel%0d", e), e < 6, 0, e == 6, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
